// File: rtl/mario_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mario_pkg
// Purpose  : Shared pose codes, FSM state encoding and screen geometry for
//            the Mario sprite pipeline (pose controller and sprite mux).
// Revision : 1.0  initial release
// ============================================================================
package mario_pkg;

    // Screen geometry used to derive the default horizontal limits
    localparam int SCREEN_W = 640;
    localparam int SPRITE_W = 32;

    // Pose codes shared with the sprite-select mux
    localparam logic [2:0] POS_STD_BACK  = 3'b000;
    localparam logic [2:0] POS_WK_BACK   = 3'b001;
    localparam logic [2:0] POS_STD_FRONT = 3'b010;
    localparam logic [2:0] POS_WK_FRONT  = 3'b011;

    // Animation FSM state encoding
    typedef enum logic [1:0] {
        STAND     = 2'd0,
        WALK_STEP = 2'd1,
        WALK_MID  = 2'd2
    } pose_state_t;

    // Per-frame direction request decoded from the synchronized buttons
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    // Pose code: bit 1 is facing (1 = front), bit 0 marks the step sprite
    function automatic logic [2:0] pose_code(input logic facing, input logic step);
        return {1'b0, facing, step};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mario_pose_ctrl_btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync
// Purpose  : Two-flop synchronizer bringing a raw button into clk25.
// Revision : 1.0  initial release
// ============================================================================
module btn_sync (
    input  logic clk25,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage capture; only the second stage is used downstream
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mario_pose_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mario_pose_ctrl
// Purpose  : Per-frame stand/walk animation FSM and clamped horizontal
//            position for the Mario sprite, clk25 domain.
// Revision : 1.0  initial release
// ============================================================================
module mario_pose_ctrl
    import mario_pkg::*;
#(
    parameter int ANIM_FRAMES = 8,
    parameter int STEP        = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = SCREEN_W - SPRITE_W,
    parameter int X_INIT      = 64
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] pos,
    output logic [9:0] x_pos,
    output logic       moving
);

    localparam int          CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);
    // Limits are compared in 11 bits so X_MIN+STEP / X_MAX-STEP never wrap
    localparam logic [10:0] LO_LIM   = 11'(X_MIN + STEP);
    localparam logic [10:0] HI_LIM   = 11'(X_MAX - STEP);

    logic              left_s;
    logic              right_s;
    dir_t              dir;
    pose_state_t       state;
    pose_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              facing;
    logic              facing_nxt;
    logic [9:0]        x_nxt;
    logic [10:0]       x_ext;

    btn_sync u_sync_left  (.clk25(clk25), .rst(rst), .din(btn_left),  .dout(left_s));
    btn_sync u_sync_right (.clk25(clk25), .rst(rst), .din(btn_right), .dout(right_s));

    assign dir   = (left_s && !right_s) ? DIR_L :
                   (right_s && !left_s) ? DIR_R : DIR_NONE;
    assign x_ext = {1'b0, x_pos};

    // Register FSM, counter, facing and the published outputs
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state  <= STAND;
            cnt    <= '0;
            facing <= 1'b1;
            x_pos  <= 10'(X_INIT);
            pos    <= POS_STD_FRONT;
            moving <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            facing <= facing_nxt;
            x_pos  <= x_nxt;
            pos    <= pose_code(facing_nxt, state_nxt == WALK_STEP);
            moving <= (state_nxt != STAND);
        end
    end

    // Next-state, animation counter and clamped X, evaluated on frame ticks only
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        facing_nxt = facing;
        x_nxt      = x_pos;
        if (frame_tick) begin
            if (dir == DIR_NONE) begin
                state_nxt = STAND;
                cnt_nxt   = '0;
            end else if (state == STAND) begin
                state_nxt  = WALK_STEP;
                cnt_nxt    = '0;
                facing_nxt = (dir == DIR_R);
            end else if ((dir == DIR_R) == facing) begin
                if (cnt == CNT_LAST) begin
                    state_nxt = (state == WALK_STEP) ? WALK_MID : WALK_STEP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                // Direction reversal restarts the walk cycle facing the new way
                facing_nxt = (dir == DIR_R);
                state_nxt  = WALK_STEP;
                cnt_nxt    = '0;
            end

            if (dir == DIR_L) begin
                x_nxt = (x_ext < LO_LIM) ? 10'(X_MIN) : 10'(x_ext - 11'(STEP));
            end else if (dir == DIR_R) begin
                x_nxt = (x_ext > HI_LIM) ? 10'(X_MAX) : 10'(x_ext + 11'(STEP));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mario_pose_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mario_pose_ctrl
// Purpose  : Directed, scoreboard-checked bench for mario_pose_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mario_pose_ctrl;

    localparam int ANIM_FRAMES = 8;
    localparam int STEP        = 2;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 608;
    localparam int X_INIT      = 64;

    typedef struct packed {
        logic [2:0] pos;
        logic [9:0] x;
        logic       mv;
    } exp_t;

    logic       clk25 = 1'b0;
    logic       rst   = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left   = 1'b0;
    logic       btn_right  = 1'b0;
    logic [2:0] pos;
    logic [9:0] x_pos;
    logic       moving;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: 0 stand, 1 walk-step, 2 walk-mid
    int   m_state;
    int   m_cnt;
    int   m_face;
    int   m_x;

    mario_pose_ctrl #(
        .ANIM_FRAMES(ANIM_FRAMES), .STEP(STEP), .X_MIN(X_MIN),
        .X_MAX(X_MAX), .X_INIT(X_INIT)
    ) dut (
        .clk25(clk25), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .pos(pos), .x_pos(x_pos), .moving(moving)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".pos"},    16'(pos),    16'(e.pos));
        chk({tag, ".x"},      16'(x_pos),  16'(e.x));
        chk({tag, ".moving"}, 16'(moving), 16'(e.mv));
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pos = {1'b0, m_face[0], (m_state == 1)};
        e.x   = 10'(m_x);
        e.mv  = (m_state != 0);
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_face = 1; m_x = X_INIT;
    endtask

    // One frame of the behavioural model given the synchronized buttons
    task automatic model_tick(input logic l, input logic r);
        int d;
        d = (l && !r) ? 1 : (r && !l) ? 2 : 0;
        if (d == 0) begin
            m_state = 0; m_cnt = 0;
        end else begin
            if (m_state == 0) begin
                m_state = 1; m_cnt = 0; m_face = (d == 2);
            end else if ((d == 2) == (m_face == 1)) begin
                if (m_cnt == ANIM_FRAMES - 1) begin
                    m_state = (m_state == 1) ? 2 : 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_face = (d == 2); m_state = 1; m_cnt = 0;
            end
            if (d == 2) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
            else        m_x = (m_x < X_MIN + STEP) ? X_MIN : m_x - STEP;
        end
    endtask

    // n back-to-back ticks; l/r are the synchronized levels the DUT will see
    task automatic tick_n(input string tag, input int n, input logic l, input logic r);
        exp_t e;
        @(negedge clk25);
        frame_tick = 1'b1;
        model_tick(l, r);
        sb.push_back(model_out());
        for (int i = 1; i < n; i++) begin
            @(negedge clk25);
            e = sb.pop_front();
            chk_all(tag, e);
            model_tick(l, r);
            sb.push_back(model_out());
        end
        @(negedge clk25);
        frame_tick = 1'b0;
        e = sb.pop_front();
        chk_all(tag, e);
        last_exp = e;
    endtask

    task automatic ticks(input string tag, input int n, input logic l, input logic r);
        for (int i = 0; i < n; i++) tick_n(tag, 1, l, r);
    endtask

    task automatic set_btn(input logic l, input logic r);
        @(negedge clk25);
        btn_left  = l;
        btn_right = r;
        repeat (2) @(negedge clk25);
    endtask

    initial begin
        exp_t e;
        model_reset();
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        chk_all("reset", model_out());

        // Idle frames: nothing moves
        ticks("idle", 5, 1'b0, 1'b0);

        // Hold right 20 frames: two full animation periods plus part of a third
        set_btn(1'b0, 1'b1);
        ticks("walk_right", 20, 1'b0, 1'b1);

        // Outputs must stay put between ticks
        repeat (3) @(negedge clk25);
        chk_all("mid_frame", last_exp);

        // Stop, walk right 4 frames, then reverse
        set_btn(1'b0, 1'b0);
        ticks("stop", 1, 1'b0, 1'b0);
        set_btn(1'b0, 1'b1);
        ticks("right4", 4, 1'b0, 1'b1);
        set_btn(1'b1, 1'b0);
        ticks("reverse", 10, 1'b1, 1'b0);

        // Keep walking left into the left wall and beyond
        ticks("left_wall", 64, 1'b1, 1'b0);

        // Both buttons: stand, facing back, X unchanged
        set_btn(1'b1, 1'b1);
        ticks("both", 2, 1'b1, 1'b1);

        // Back-to-back ticks while walking right
        set_btn(1'b0, 1'b1);
        tick_n("b2b", 3, 1'b0, 1'b1);
        ticks("walk_pre_rst", 3, 1'b0, 1'b1);

        // Asynchronous reset between ticks
        @(negedge clk25);
        #5 rst = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst", model_out());
        @(negedge clk25);
        rst = 1'b0;
        repeat (3) @(negedge clk25);
        ticks("post_rst", 1, 1'b0, 1'b1);

        // Raw edge one cycle before the tick is not seen until the next frame
        set_btn(1'b0, 1'b0);
        ticks("idle2", 1, 1'b0, 1'b0);
        @(negedge clk25);
        btn_right = 1'b1;
        tick_n("late_edge", 1, 1'b0, 1'b0);
        repeat (2) @(negedge clk25);
        ticks("late_edge_next", 1, 1'b0, 1'b1);

        // Right wall clamp
        ticks("right_wall", 310, 1'b0, 1'b1);
        e = model_out();
        chk("right_wall_final.x", 16'(x_pos), 16'(X_MAX));
        chk_all("right_wall_final", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mario_pose_ctrl.md
# mario_pose_ctrl

Per-frame pose and horizontal-position controller for the Mario sprite. Samples the left/right buttons once per video frame and runs a stand/walk animation state machine. Produces the 3-bit `pos` pose code consumed by the sprite-select mux, plus the sprite X coordinate used by the pixel address generator. Runs entirely in the 25 MHz pixel clock domain.

## Interface
Parameters:
- `ANIM_FRAMES`, 8: frames each walk sprite is held before alternating.
- `STEP`, 2: pixels moved per frame while walking.
- `X_MIN`, 0: leftmost legal sprite X.
- `X_MAX`, 608: rightmost legal sprite X (640 − 32-px sprite).
- `X_INIT`, 64: sprite X after reset.

Ports:
- `clk25`  in  1  25 MHz pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per video frame (start of vertical blank).
- `btn_left`  in  1  raw left button, asynchronous, active-high.
- `btn_right`  in  1  raw right button, asynchronous, active-high.
- `pos`  out  3  pose code: 000 std-back, 001 walk-back, 010 std-front, 011 walk-front.
- `x_pos`  out  10  sprite left-edge X, unsigned.
- `moving`  out  1  high while the FSM is in a walk state.

## Operation
- Buttons pass through a 2-flop synchronizer. Only the synchronized values are used.
- Direction request, evaluated only on cycles with `frame_tick`=1:
  - left only → L.
  - right only → R.
  - neither or both → NONE.
- Facing register: L sets back (0), R sets front (1), NONE holds. Reset value: front.
- FSM states STAND, WALK_STEP, WALK_MID. State changes occur only on `frame_tick`:
  - NONE → STAND, anim counter ← 0.
  - STAND + L/R → WALK_STEP, counter ← 0.
  - Walk state, same direction as facing: counter+1. When the counter equals ANIM_FRAMES−1, toggle WALK_STEP↔WALK_MID and set counter ← 0.
  - Walk state, direction reversal: facing flips, state → WALK_STEP, counter ← 0.
- Pose encoding: `pos` = {1'b0, facing, state==WALK_STEP}. Bit 2 is always 0.
- X update, applied on `frame_tick` when the request is L/R:
  - Uses the new request, including the first frame out of STAND.
  - L: if `x_pos` < X_MIN+STEP, `x_pos` ← X_MIN; else `x_pos` − STEP.
  - R: if `x_pos` > X_MAX−STEP, `x_pos` ← X_MAX; else `x_pos` + STEP.
  - Compare in 11 bits so there is no underflow or overflow.
- At a wall the clamp holds X, but the animation continues. `moving` stays 1.
- Reset, asynchronous, any time:
  - `pos`=3'b010, `x_pos`=X_INIT, `moving`=0.
  - State STAND, counter 0, synchronizers 0.
  - Any frame in progress is abandoned.

## Timing
- `pos`, `x_pos` and `moving` are registered. They update on the clk25 edge that samples `frame_tick`=1, so they are visible one cycle after the tick.
- They are stable for the rest of the frame; downstream samples them mid-frame without hazard.
- Button-to-effect latency:
  - The synchronized level must be present at the tick edge.
  - A raw edge must therefore arrive ≥2 clk25 cycles before the tick edge.
  - Later edges apply at the next frame.
- Back-to-back `frame_tick` on consecutive cycles is legal; each tick is processed independently.
- `rst` deassertion mid-frame: the first update happens at the next `frame_tick`.

## Structure
- Shared package `mario_pkg` holds:
  - Pose constants POS_STD_BACK/POS_WK_BACK/POS_STD_FRONT/POS_WK_FRONT, also used by the sprite mux.
  - FSM state encoding.
  - Screen-width constants.
- One sub-module: `btn_sync`, a 2-flop synchronizer with async active-high reset, instantiated once per button.

## Test plan
- Reset, then 5 ticks with no buttons → `pos`=010, `x_pos`=64, `moving`=0 throughout.
- Hold right for 20 ticks (ANIM_FRAMES=8):
  - `pos`=011 for ticks 1–8, 010 for ticks 9–16, 011 for ticks 17–20.
  - `x_pos` increases 66, 68, … 104.
  - `moving`=1 throughout.
- Walk right, then switch to left at the tick-5 boundary → that tick gives `pos`=001 and `x_pos` decreases by 2; counter restarts (held 8 frames).
- Left with `x_pos`=1 → clamps to 0. Further left ticks keep 0 while `pos` keeps alternating 001/000.
- Both buttons held while facing back → `pos`=000, `x_pos` unchanged, `moving`=0.
- Assert `rst` mid-walk between ticks → outputs return to 010/64/0 asynchronously. The first post-reset tick with right held gives `pos`=011, `x_pos`=66.
- Raw right edge 1 cycle before a tick → ignored that frame; takes effect on the following tick.
